sample_sched_ctrl: RTL and testbench
====================================

# sample_sched_ctrl

Multi-cycle, resource-constrained evaluator for the five-input sample logic network (inputs a–e, outputs o/p). A fixed schedule drives one or two shared logic-unit lanes and stores intermediates in registers. It replaces the flat combinational netlist where gate area matters more than latency. It also serves as the hardware check of our list-scheduling results.

## Interface
- `LANES`, default 1: number of shared logic-unit lanes. Legal values are 1 and 2; any other value is an elaboration error.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  request evaluation. Sampled only in IDLE.
- `a`,`b`,`c`,`d`,`e`  in  1 each  operands, captured on the cycle `start` is accepted.
- `busy`  out  1  high in EXEC and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `o`,`p`  out  1 each  results, registered, held until the next DONE.

## Operation
- Reference function (golden):
  - f=a|b; g=b&d; h=f^g; i=c|h; j=e|f|g; k=i&j; l=!d&e; o=!l; p=!k.
- Lane operations (opcodes): OR, AND, XOR, ANDN (!x&y), NOT.
  - The 3-input OR j is split as j1=e|f, then j=j1|g. That gives 10 ops in total.
- Schedule, LANES=1 (10 steps, one op per step): f, g, l, o, h, i, j1, j, k, p.
- Schedule, LANES=2 (5 steps, lane0/lane1):
  - s0: f/g
  - s1: h/j1
  - s2: i/j
  - s3: k/l
  - s4: p/o
- Each step reads operands from the captured-input registers or the intermediate registers. The step's result is written at the end of the step's cycle.
  - A step never reads a value written in the same step.
- FSM states:
  - IDLE: `start`=1 captures a–e, clears the intermediates, sets step=0, goes to EXEC. `start`=0 stays in IDLE.
  - EXEC: executes schedule[step] and increments step. After step STEPS-1, copies o/p into the output registers and goes to DONE.
  - DONE: `done`=1, then returns to IDLE unconditionally.
- `start` in EXEC or DONE is ignored. It is not queued.
- Operand changes after capture have no effect on the running evaluation.
- Reset values:
  - FSM in IDLE, step=0, intermediates 0.
  - `busy`=0, `done`=0, `o`=1, `p`=1. These equal the golden result for all-zero inputs.
- `rst` during EXEC or DONE:
  - Aborts the evaluation with no `done` pulse.
  - Restores all reset values on the next cycle.
  - `rst` has priority over `start` in the same cycle.

## Timing
- `start` accepted in cycle T (IDLE). EXEC occupies T+1 … T+STEPS.
- DONE in cycle T+STEPS+1: `done`=1 and new `o`/`p` visible.
  - LANES=1: done at T+11.
  - LANES=2: done at T+6.
- `busy`=1 from T+1 through T+STEPS+1.
- The earliest next accept is T+STEPS+2, giving a throughput of one evaluation per STEPS+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `sample_sched_pkg` holds:
  - The opcode enum: OR/AND/XOR/ANDN/NOT.
  - The operand-select enum: IN_A..IN_E, F, G, H, I, J1, J, K, L.
  - The destination enum.
  - The step-entry struct {op, src0, src1, dst}.
  - Two constant schedule arrays, SCHED1[10] and SCHED2[5][2].
  - The STEPS function of LANES.
- Sub-module `sample_sched_lu` is a purely combinational 1-bit logic unit (op, x, y → z). It is instantiated LANES times.
- The controller contains the FSM, step counter, operand muxes, intermediate register bank and output registers.

## Test plan
- Reset, then idle: `o`=1, `p`=1, `busy`=0, `done`=0 for 5 cycles.
- a=1,b=0,c=0,d=0,e=1 with `start` at T:
  - Required result `o`=0, `p`=0.
  - `done` only at T+11 (LANES=1) or T+6 (LANES=2).
  - `busy` high exactly over the EXEC/DONE window.
- a=0,b=1,c=0,d=1,e=0:
  - Required result `o`=1, `p`=1.
  - Then a=1,b=1,c=1,d=0,e=0 (f=1,g=0,h=1,i=1,j=1,k=1,l=0) must give `o`=1, `p`=0.
- `start` held high continuously:
  - Accepts occur every 12 cycles (LANES=1) or every 7 cycles (LANES=2).
  - Toggling a–e mid-run does not alter the result for the captured vector.
- `rst` pulsed at T+4 of a run:
  - No `done` pulse.
  - `o`/`p` return to 1/1.
  - A new `start` at T+6 completes correctly.
- All 32 input vectors run back-to-back for both LANES values. Every `o`/`p` must match the golden equations.

Source files
------------

// File: rtl/sample_sched_pkg.sv
// Shared types and constant schedules for the time-multiplexed sample-network evaluator.
// Operand pool layout: captured inputs a..e occupy bits 0..4, intermediates f..l bits 5..12.
package sample_sched_pkg;

    typedef enum logic [2:0] {
        OP_OR   = 3'd0,
        OP_AND  = 3'd1,
        OP_XOR  = 3'd2,
        OP_ANDN = 3'd3,
        OP_NOT  = 3'd4
    } op_e;

    typedef enum logic [3:0] {
        IN_A   = 4'd0,
        IN_B   = 4'd1,
        IN_C   = 4'd2,
        IN_D   = 4'd3,
        IN_E   = 4'd4,
        SRC_F  = 4'd5,
        SRC_G  = 4'd6,
        SRC_H  = 4'd7,
        SRC_I  = 4'd8,
        SRC_J1 = 4'd9,
        SRC_J  = 4'd10,
        SRC_K  = 4'd11,
        SRC_L  = 4'd12
    } src_e;

    typedef enum logic [3:0] {
        DST_F  = 4'd0,
        DST_G  = 4'd1,
        DST_H  = 4'd2,
        DST_I  = 4'd3,
        DST_J1 = 4'd4,
        DST_J  = 4'd5,
        DST_K  = 4'd6,
        DST_L  = 4'd7,
        DST_O  = 4'd8,
        DST_P  = 4'd9
    } dst_e;

    localparam int unsigned NUM_INT = 10;

    typedef struct packed {
        op_e  op;
        src_e src0;
        src_e src1;
        dst_e dst;
    } step_t;

    // ANDN computes !src0 & src1; NOT uses src0 only.
    localparam step_t SCHED1 [10] = '{
        '{OP_OR,   IN_A,   IN_B,   DST_F},
        '{OP_AND,  IN_B,   IN_D,   DST_G},
        '{OP_ANDN, IN_D,   IN_E,   DST_L},
        '{OP_NOT,  SRC_L,  SRC_L,  DST_O},
        '{OP_XOR,  SRC_F,  SRC_G,  DST_H},
        '{OP_OR,   IN_C,   SRC_H,  DST_I},
        '{OP_OR,   IN_E,   SRC_F,  DST_J1},
        '{OP_OR,   SRC_J1, SRC_G,  DST_J},
        '{OP_AND,  SRC_I,  SRC_J,  DST_K},
        '{OP_NOT,  SRC_K,  SRC_K,  DST_P}
    };

    localparam step_t SCHED2 [5][2] = '{
        '{'{OP_OR,  IN_A,  IN_B,  DST_F},  '{OP_AND,  IN_B,   IN_D,  DST_G}},
        '{'{OP_XOR, SRC_F, SRC_G, DST_H},  '{OP_OR,   IN_E,   SRC_F, DST_J1}},
        '{'{OP_OR,  IN_C,  SRC_H, DST_I},  '{OP_OR,   SRC_J1, SRC_G, DST_J}},
        '{'{OP_AND, SRC_I, SRC_J, DST_K},  '{OP_ANDN, IN_D,   IN_E,  DST_L}},
        '{'{OP_NOT, SRC_K, SRC_K, DST_P},  '{OP_NOT,  SRC_L,  SRC_L, DST_O}}
    };

    function automatic int unsigned sched_steps(input int unsigned lanes);
        return (lanes == 32'd2) ? 32'd5 : 32'd10;
    endfunction

    function automatic step_t sched_entry(input int unsigned lanes, input logic [3:0] step,
                                          input logic lane);
        step_t r;
        r = SCHED1[0];
        if (lanes == 32'd2) begin
            if (step < 4'd5) r = SCHED2[step[2:0]][lane];
            else             r = SCHED2[0][lane];
        end else begin
            if (step < 4'd10) r = SCHED1[step];
            else              r = SCHED1[0];
        end
        return r;
    endfunction

    function automatic logic sel_operand(input src_e s, input logic [4:0] in_v,
                                         input logic [7:0] mid_v);
        logic [12:0] pool;
        pool = {mid_v, in_v};
        return pool[s];
    endfunction

endpackage

// File: rtl/sample_sched_lu.sv
// One-bit shared logic unit: purely combinational, one opcode per cycle.
module sample_sched_lu
    import sample_sched_pkg::*;
(
    input  op_e  op_i,
    input  logic x_i,
    input  logic y_i,
    output logic z_o
);

    // Opcode decode
    always_comb begin
        z_o = 1'b0;
        case (op_i)
            OP_OR:   z_o = x_i | y_i;
            OP_AND:  z_o = x_i & y_i;
            OP_XOR:  z_o = x_i ^ y_i;
            OP_ANDN: z_o = ~x_i & y_i;
            OP_NOT:  z_o = ~x_i;
            default: z_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sample_sched_ctrl.sv
// Scheduled evaluator of the five-input sample network over LANES shared logic units.
// Captures a..e on start, runs the fixed schedule, then publishes o/p with a done pulse.
module sample_sched_ctrl
    import sample_sched_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    output logic busy,
    output logic done,
    output logic o,
    output logic p
);

    if (!(LANES == 1 || LANES == 2)) begin : g_lanes_check
        $error("sample_sched_ctrl: LANES must be 1 or 2");
    end

    localparam int unsigned STEPS     = sched_steps(LANES);
    localparam logic [3:0]  LAST_STEP = 4'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic [3:0]           step_q;
    logic [4:0]           in_q;
    logic [NUM_INT-1:0]   int_q;
    logic [NUM_INT-1:0]   int_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 o_q;
    logic                 p_q;

    step_t                lane_step_s [LANES];
    logic [LANES-1:0]     lane_x_s;
    logic [LANES-1:0]     lane_y_s;
    logic [LANES-1:0]     lane_z_s;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_step_s[gi] = sched_entry(LANES, step_q, 1'(gi));
        assign lane_x_s[gi]    = sel_operand(lane_step_s[gi].src0, in_q, int_q[7:0]);
        assign lane_y_s[gi]    = sel_operand(lane_step_s[gi].src1, in_q, int_q[7:0]);

        sample_sched_lu u_lu (
            .op_i (lane_step_s[gi].op),
            .x_i  (lane_x_s[gi]),
            .y_i  (lane_y_s[gi]),
            .z_o  (lane_z_s[gi])
        );
    end

    // Intermediate bank next state: operands come from int_q, so a step never sees its own writes
    always_comb begin
        int_d = int_q;
        for (int l = 0; l < LANES; l++) begin
            int_d[lane_step_s[l].dst] = lane_z_s[l];
        end
    end

    // Control FSM, step counter, register bank and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= 4'd0;
            in_q    <= 5'd0;
            int_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            o_q     <= 1'b1;
            p_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        in_q    <= {e, d, c, b, a};
                        int_q   <= '0;
                        step_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    int_q <= int_d;
                    if (step_q == LAST_STEP) begin
                        o_q     <= int_d[DST_O];
                        p_q     <= int_d[DST_P];
                        done_q  <= 1'b1;
                        step_q  <= 4'd0;
                        state_q <= ST_DONE;
                    end else begin
                        step_q  <= step_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign o    = o_q;
    assign p    = p_q;

endmodule

// File: tb/tb_sample_sched_ctrl.sv
// Self-checking bench: one instance per legal LANES value, golden-equation reference model.
module tb_sample_sched_ctrl;

    logic       clk = 1'b0;
    logic [1:0] rst_v   = 2'b11;
    logic [1:0] start_v = 2'b00;
    logic [4:0] in_v [2];
    logic [1:0] busy_v, done_v, o_v, p_v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sample_sched_ctrl #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
        .a(in_v[0][0]), .b(in_v[0][1]), .c(in_v[0][2]), .d(in_v[0][3]), .e(in_v[0][4]),
        .busy(busy_v[0]), .done(done_v[0]), .o(o_v[0]), .p(p_v[0])
    );

    sample_sched_ctrl #(.LANES(2)) u_dut2 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
        .a(in_v[1][0]), .b(in_v[1][1]), .c(in_v[1][2]), .d(in_v[1][3]), .e(in_v[1][4]),
        .busy(busy_v[1]), .done(done_v[1]), .o(o_v[1]), .p(p_v[1])
    );

    // Reference network; vector bit 0 is a, bit 4 is e. Returns {o, p}.
    function automatic logic [1:0] golden(input logic [4:0] v);
        logic va, vb, vc, vd, ve, f, g, h, i, j, k, l;
        {ve, vd, vc, vb, va} = v;
        f = va | vb;
        g = vb & vd;
        h = f ^ g;
        i = vc | h;
        j = ve | f | g;
        k = i & j;
        l = ~vd & ve;
        return {~l, ~k};
    endfunction

    function automatic int steps_of(input int u);
        return (u == 0) ? 10 : 5;
    endfunction

    // One evaluation: accept at cycle T, watch busy/done each cycle up to T+STEPS+1.
    task automatic run_eval(input int u, input logic [4:0] vec, input bit scramble, input bit hold);
        int         steps;
        logic [1:0] exp_op;
        logic       exp_done;
        steps  = steps_of(u);
        exp_op = golden(vec);
        @(negedge clk);
        checks++;
        if (busy_v[u] !== 1'b0 || done_v[u] !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_start lanes=%0d: busy=%b done=%b want 0/0", u + 1, busy_v[u], done_v[u]);
        end
        in_v[u]    = vec;
        start_v[u] = 1'b1;
        for (int k = 1; k <= steps + 1; k++) begin
            @(negedge clk);
            if (!hold) start_v[u] = 1'b0;
            if (scramble) in_v[u] = 5'($urandom);
            exp_done = (k == steps + 1);
            checks++;
            if (busy_v[u] !== 1'b1) begin
                errors++;
                $display("FAIL busy lanes=%0d T+%0d: got %b want 1", u + 1, k, busy_v[u]);
            end
            checks++;
            if (done_v[u] !== exp_done) begin
                errors++;
                $display("FAIL done_timing lanes=%0d T+%0d: got %b want %b", u + 1, k, done_v[u], exp_done);
            end
            if (exp_done) begin
                checks++;
                if ({o_v[u], p_v[u]} !== exp_op) begin
                    errors++;
                    $display("FAIL result lanes=%0d vec=%b: got o/p=%b want %b", u + 1, vec, {o_v[u], p_v[u]}, exp_op);
                end
            end
        end
    endtask

    task automatic test_reset(input int u);
        @(negedge clk);
        rst_v[u] = 1'b1;
        @(negedge clk);
        rst_v[u] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if ({busy_v[u], done_v[u], o_v[u], p_v[u]} !== 4'b0011) begin
                errors++;
                $display("FAIL reset_idle lanes=%0d cyc%0d: busy/done/o/p=%b want 0011",
                         u + 1, n, {busy_v[u], done_v[u], o_v[u], p_v[u]});
            end
        end
    endtask

    task automatic test_directed(input int u);
        logic [4:0] vecs [3];
        logic [1:0] want [3];
        vecs[0] = 5'b10001; want[0] = 2'b00;
        vecs[1] = 5'b01010; want[1] = 2'b11;
        vecs[2] = 5'b00111; want[2] = 2'b10;
        for (int n = 0; n < 3; n++) begin
            run_eval(u, vecs[n], 1'b0, 1'b0);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({o_v[u], p_v[u]} !== want[n]) begin
                errors++;
                $display("FAIL directed_held lanes=%0d vec=%b: got %b want %b", u + 1, vecs[n], {o_v[u], p_v[u]}, want[n]);
            end
        end
    endtask

    task automatic test_start_held(input int u);
        for (int n = 0; n < 3; n++) begin
            run_eval(u, 5'($urandom), 1'b1, 1'b1);
        end
        start_v[u] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy_v[u] !== 1'b0) begin
            errors++;
            $display("FAIL start_not_queued lanes=%0d: busy=%b want 0", u + 1, busy_v[u]);
        end
    endtask

    task automatic test_rst_abort(input int u);
        run_eval(u, 5'b10001, 1'b0, 1'b0);
        @(negedge clk);
        in_v[u]    = 5'b10001;
        start_v[u] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start_v[u] = 1'b0;
            checks++;
            if (done_v[u] !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done lanes=%0d T+%0d: done=%b want 0", u + 1, k, done_v[u]);
            end
        end
        rst_v[u]   = 1'b1;
        start_v[u] = 1'b1;
        @(negedge clk);
        rst_v[u]   = 1'b0;
        start_v[u] = 1'b0;
        checks++;
        if ({busy_v[u], done_v[u], o_v[u], p_v[u]} !== 4'b0011) begin
            errors++;
            $display("FAIL abort_restore lanes=%0d: busy/done/o/p=%b want 0011",
                     u + 1, {busy_v[u], done_v[u], o_v[u], p_v[u]});
        end
        run_eval(u, 5'b00111, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back(input int u);
        for (int v = 0; v < 32; v++) begin
            run_eval(u, 5'(v), 1'b1, 1'b0);
        end
        for (int n = 0; n < 6; n++) begin
            run_eval(u, 5'($urandom), 1'b1, 1'b0);
        end
    endtask

    initial begin
        in_v[0] = 5'd0;
        in_v[1] = 5'd0;
        repeat (2) @(negedge clk);
        rst_v = 2'b00;
        for (int u = 0; u < 2; u++) begin
            test_reset(u);
            test_directed(u);
            test_start_held(u);
            test_rst_abort(u);
            test_back_to_back(u);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
